// File: rtl/reorder_buffer.sv
// reorder_buffer: two-wide in-order reorder buffer sitting after register_renamer.
// Tracks dispatched instructions until completion, retires up to two per cycle
// in program order and returns superseded physical registers to the renamer.
// Optional feature macro: ROB_FLUSH_EN (adds flush_i, clears all in-flight state).
module reorder_buffer #(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned NUM_P_REGS  = 64,
  localparam int unsigned TW = $clog2(NUM_ENTRIES),
  localparam int unsigned PW = $clog2(NUM_P_REGS)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
`ifdef ROB_FLUSH_EN
  input  logic          flush_i,
`endif
  input  logic          alloc0_en_i,
  input  logic          alloc1_en_i,
  input  logic          alloc0_has_dest_i,
  input  logic          alloc1_has_dest_i,
  input  logic [PW-1:0] alloc0_old_preg_i,
  input  logic [PW-1:0] alloc1_old_preg_i,
  output logic [TW-1:0] alloc0_tag_o,
  output logic [TW-1:0] alloc1_tag_o,
  output logic          full_o,
  output logic          empty_o,
  input  logic          cmpl0_en_i,
  input  logic          cmpl1_en_i,
  input  logic [TW-1:0] cmpl0_tag_i,
  input  logic [TW-1:0] cmpl1_tag_i,
  output logic          en_free_reg0_o,
  output logic          en_free_reg1_o,
  output logic [PW-1:0] free_reg0_o,
  output logic [PW-1:0] free_reg1_o
);

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] done_q;
  logic [NUM_ENTRIES-1:0] has_dest_q;
  logic [PW-1:0]          old_preg_q [NUM_ENTRIES];

  logic [TW-1:0] head_q;
  logic [TW-1:0] tail_q;
  logic [TW:0]   count_q;

  logic          flush;
  logic [TW-1:0] head1;
  logic          acc0, acc1;
  logic          ret0, ret1;
  logic [TW:0]   n_alloc, n_ret;
  logic          free0_en, free1_en;
  logic [PW-1:0] free0_val, free1_val;

`ifdef ROB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Tags, status flags, accept/retire decisions from pre-edge state
  always_comb begin
    full_o       = (count_q >= (TW+1)'(NUM_ENTRIES - 1));
    empty_o      = (count_q == '0);
    alloc0_tag_o = tail_q;
    // Slots are compacted: a lone alloc1 takes the tail entry
    alloc1_tag_o = alloc0_en_i ? tail_q + TW'(1) : tail_q;

    acc0 = alloc0_en_i & ~full_o;
    acc1 = alloc1_en_i & ~full_o;

    head1 = head_q + TW'(1);
    ret0  = valid_q[head_q] & done_q[head_q];
    ret1  = ret0 & valid_q[head1] & done_q[head1];

    n_alloc = (TW+1)'(acc0) + (TW+1)'(acc1);
    n_ret   = (TW+1)'(ret0) + (TW+1)'(ret1);

    free0_en  = ret0 & has_dest_q[head_q];
    free1_en  = ret1 & has_dest_q[head1];
    free0_val = free0_en ? old_preg_q[head_q] : '0;
    free1_val = free1_en ? old_preg_q[head1]  : '0;
  end

  // Entry state, pointers, count and registered free pulses
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      en_free_reg0_o <= 1'b0;
      en_free_reg1_o <= 1'b0;
      free_reg0_o    <= '0;
      free_reg1_o    <= '0;
    end else begin
      // Completions only land on valid entries; the tail slots written below
      // are never valid, and a retiring head is already done, so the later
      // clears/writes cannot lose a completion.
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_q[i] &&
            ((cmpl0_en_i && cmpl0_tag_i == TW'(i)) ||
             (cmpl1_en_i && cmpl1_tag_i == TW'(i)))) begin
          done_q[i] <= 1'b1;
        end
      end

      if (ret0) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
      if (ret1) begin
        valid_q[head1] <= 1'b0;
        done_q[head1]  <= 1'b0;
      end

      if (acc0) begin
        valid_q[alloc0_tag_o]    <= 1'b1;
        done_q[alloc0_tag_o]     <= 1'b0;
        has_dest_q[alloc0_tag_o] <= alloc0_has_dest_i;
        old_preg_q[alloc0_tag_o] <= alloc0_old_preg_i;
      end
      if (acc1) begin
        valid_q[alloc1_tag_o]    <= 1'b1;
        done_q[alloc1_tag_o]     <= 1'b0;
        has_dest_q[alloc1_tag_o] <= alloc1_has_dest_i;
        old_preg_q[alloc1_tag_o] <= alloc1_old_preg_i;
      end

      head_q  <= head_q + TW'(n_ret);
      tail_q  <= tail_q + TW'(n_alloc);
      count_q <= count_q + n_alloc - n_ret;

      en_free_reg0_o <= free0_en;
      en_free_reg1_o <= free1_en;
      free_reg0_o    <= free0_val;
      free_reg1_o    <= free1_val;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic checked against
// a program-order queue model of the reorder buffer.
module tb_reorder_buffer;

  localparam int N = 16;
  localparam int P = 64;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       a0, a1, hd0, hd1;
  logic [5:0] p0, p1;
  logic       c0, c1;
  logic [3:0] ct0, ct1;

  logic [3:0] tag0, tag1;
  logic       full, empty;
  logic       fen0, fen1;
  logic [5:0] freg0, freg1;

  int n_cmp = 0;
  int n_err = 0;

  reorder_buffer #(.NUM_ENTRIES(N), .NUM_P_REGS(P)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
`ifdef ROB_FLUSH_EN
    .flush_i           (flush),
`endif
    .alloc0_en_i       (a0),
    .alloc1_en_i       (a1),
    .alloc0_has_dest_i (hd0),
    .alloc1_has_dest_i (hd1),
    .alloc0_old_preg_i (p0),
    .alloc1_old_preg_i (p1),
    .alloc0_tag_o      (tag0),
    .alloc1_tag_o      (tag1),
    .full_o            (full),
    .empty_o           (empty),
    .cmpl0_en_i        (c0),
    .cmpl1_en_i        (c1),
    .cmpl0_tag_i       (ct0),
    .cmpl1_tag_i       (ct1),
    .en_free_reg0_o    (fen0),
    .en_free_reg1_o    (fen1),
    .free_reg0_o       (freg0),
    .free_reg1_o       (freg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight instructions in program order
  typedef struct {
    int tag;
    bit hd;
    int preg;
    bit done;
  } ent_t;

  ent_t rob[$];
  int   m_tail;
  bit   e_en0, e_en1;
  int   e_f0, e_f1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    rob.delete();
    m_tail = 0;
    e_en0 = 0; e_en1 = 0; e_f0 = 0; e_f1 = 0;
  endtask

  // Apply one clock edge to the model using the currently driven inputs
  task automatic model_edge();
    bit   full_m, r0, r1;
    ent_t e;
    if (!rst_n || flush) begin
      model_clear();
      return;
    end
    full_m = rob.size() >= N - 1;
    r0 = rob.size() > 0 && rob[0].done;
    r1 = r0 && rob.size() > 1 && rob[1].done;
    e_en0 = 0; e_f0 = 0; e_en1 = 0; e_f1 = 0;
    if (r0 && rob[0].hd) begin e_en0 = 1; e_f0 = rob[0].preg; end
    if (r1 && rob[1].hd) begin e_en1 = 1; e_f1 = rob[1].preg; end
    if (r0) void'(rob.pop_front());
    if (r1) void'(rob.pop_front());
    foreach (rob[i])
      if ((c0 && rob[i].tag == int'(ct0)) || (c1 && rob[i].tag == int'(ct1)))
        rob[i].done = 1;
    if (!full_m) begin
      if (a0) begin
        e = '{tag: m_tail, hd: hd0, preg: int'(p0), done: 0};
        rob.push_back(e);
        m_tail = (m_tail + 1) % N;
      end
      if (a1) begin
        e = '{tag: m_tail, hd: hd1, preg: int'(p1), done: 0};
        rob.push_back(e);
        m_tail = (m_tail + 1) % N;
      end
    end
  endtask

  // One cycle: compare outputs mid-cycle, advance the model, cross the edge
  task automatic step();
    @(negedge clk);
    check("empty", empty, rob.size() == 0);
    check("full", full, rob.size() >= N - 1);
    check("tag0", tag0, m_tail);
    check("tag1", tag1, a0 ? (m_tail + 1) % N : m_tail);
    check("en_free0", fen0, e_en0);
    check("free_reg0", freg0, e_f0);
    check("en_free1", fen1, e_en1);
    check("free_reg1", freg1, e_f1);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1; flush = 0;
    a0 = 0; a1 = 0; hd0 = 0; hd1 = 0; p0 = '0; p1 = '0;
    c0 = 0; c1 = 0; ct0 = '0; ct1 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1;

    // Reset state
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_tag0", tag0, 0);
    check("rst_en0", fen0, 0);
    check("rst_en1", fen1, 0);
    check("rst_f0", freg0, 0);
    check("rst_f1", freg1, 0);

    // Basic dispatch pair, complete out of order, retire together
    a0 = 1; a1 = 1; hd0 = 1; hd1 = 1; p0 = 6'd5; p1 = 6'd9;
    step();
    idle(); c0 = 1; ct0 = 4'd1;
    step();
    idle(); c1 = 1; ct1 = 4'd0;
    step();
    idle();
    step();
    check("basic_en0", fen0, 1);
    check("basic_f0", freg0, 5);
    check("basic_en1", fen1, 1);
    check("basic_f1", freg1, 9);
    step();
    check("basic_pulse_end", fen0, 0);

    // No destination: retires without a free pulse
    a0 = 1; hd0 = 0; p0 = 6'd7;
    step();
    idle(); c0 = 1; ct0 = 4'd2;
    step();
    idle();
    step();
    check("nodest_en0", fen0, 0);
    check("nodest_empty", empty, 1);

    // Out-of-order completion and invalid-tag completion
    do_reset();
    a0 = 1; a1 = 1; hd0 = 1; hd1 = 1; p0 = 6'd11; p1 = 6'd12;
    step();
    idle(); c0 = 1; ct0 = 4'd1;
    step();
    idle(); c1 = 1; ct1 = 4'd9;
    step();
    idle();
    step();
    check("ooo_hold_empty", empty, 0);
    check("ooo_hold_en0", fen0, 0);
    c0 = 1; ct0 = 4'd0;
    step();
    idle();
    step();
    check("ooo_f0", freg0, 11);
    check("ooo_f1", freg1, 12);

    // Full, dropped alloc, then wrap of the tail
    do_reset();
    for (int i = 0; i < 7; i++) begin
      a0 = 1; a1 = 1; hd0 = 1; hd1 = 1;
      p0 = 6'($urandom_range(0, P - 1)); p1 = 6'($urandom_range(0, P - 1));
      step();
    end
    idle(); a0 = 1; hd0 = 1; p0 = 6'd3;
    step();
    idle();
    #1;
    check("full_at_15", full, 1);
    a0 = 1; a1 = 1;
    step();
    idle();
    #1;
    check("drop_tail", tag0, 15);
    c0 = 1; ct0 = 4'd0; c1 = 1; ct1 = 4'd1;
    step();
    idle();
    step();
    check("full_cleared", full, 0);
    a0 = 1; a1 = 1;
    #1;
    check("wrap_tag0", tag0, 15);
    check("wrap_tag1", tag1, 0);
    step();
    idle();

    // Mid-run reset with six entries in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a0 = 1; a1 = 1; hd0 = 1; hd1 = 1; p0 = 6'd20; p1 = 6'd21;
      step();
    end
    idle(); c0 = 1; ct0 = 4'd0;
    step();
    idle();
    rst_n = 0; c0 = 1; ct0 = 4'd1; a0 = 1;
    step();
    idle();
    check("midrst_empty", empty, 1);
    check("midrst_tag0", tag0, 0);
    check("midrst_en0", fen0, 0);
    check("midrst_en1", fen1, 0);

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      a0 = 1; a1 = 1; hd0 = 1; hd1 = 1; p0 = 6'd30; p1 = 6'd31;
      step();
    end
    idle(); c0 = 1; ct0 = 4'd0; c1 = 1; ct1 = 4'd1;
    step();
    idle();
    flush = 1; a0 = 1;
    step();
    idle();
    check("flush_empty", empty, 1);
    check("flush_tag0", tag0, 0);
    check("flush_en0", fen0, 0);
    check("flush_en1", fen1, 0);
`endif

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      rst_n = ($urandom_range(0, 199) != 0);
`ifdef ROB_FLUSH_EN
      flush = ($urandom_range(0, 149) == 0);
`endif
      a0  = ($urandom_range(0, 9) < 5);
      a1  = ($urandom_range(0, 9) < 4);
      hd0 = ($urandom_range(0, 3) != 0);
      hd1 = ($urandom_range(0, 3) != 0);
      p0  = 6'($urandom_range(0, P - 1));
      p1  = 6'($urandom_range(0, P - 1));
      c0  = ($urandom_range(0, 9) < 6);
      c1  = ($urandom_range(0, 9) < 4);
      if (rob.size() > 0 && $urandom_range(0, 9) < 8)
        ct0 = 4'(rob[$urandom_range(0, rob.size() - 1)].tag);
      else
        ct0 = 4'($urandom_range(0, N - 1));
      if (rob.size() > 0 && $urandom_range(0, 9) < 8)
        ct1 = 4'(rob[$urandom_range(0, rob.size() - 1)].tag);
      else
        ct1 = 4'($urandom_range(0, N - 1));
      step();
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
